// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int OP_W  = 3;
  localparam int REG_W = 5;

  // funct3 values of the RV32M extension
  typedef enum logic [OP_W-1:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input logic [OP_W-1:0] o);
    return o[2];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring unsigned divider: one quotient bit per step; outputs show the post-step values.
module muldiv_div_core #(
  parameter int DWIDTH = 32
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DWIDTH-1:0] dividend_i,
  input  logic [DWIDTH-1:0] divisor_i,
  output logic [DWIDTH-1:0] quotient_o,
  output logic [DWIDTH-1:0] remainder_o
);

  logic [DWIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dsr_q;
  logic [DWIDTH:0]   shifted, diff;

  always_comb begin
    shifted = {rem_q, quo_q[DWIDTH-1]};
    diff    = shifted - {1'b0, dsr_q};
    if (diff[DWIDTH]) begin
      rem_d = shifted[DWIDTH-1:0];
      quo_d = {quo_q[DWIDTH-2:0], 1'b0};
    end else begin
      rem_d = diff[DWIDTH-1:0];
      quo_d = {quo_q[DWIDTH-2:0], 1'b1};
    end
  end

  // Post-step values let the top latch the final bit on the same edge it leaves DIV.
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dsr_q <= divisor_i;
    end else if (step_i) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file write-back.
// MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier instead of shift-add.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DWIDTH-1:0] opA,
  input  logic [DWIDTH-1:0] opB,
  input  logic [REG_W-1:0]  rd,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] result,
  output logic [REG_W-1:0]  waddr
);

  localparam int CW = $clog2(DWIDTH) + 1;

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [REG_W-1:0]    rd_q, waddr_q, waddr_d;
  logic [CW-1:0]       cnt_q;
  logic [DWIDTH-1:0]   mcand_q, result_q, result_d;
  logic [2*DWIDTH-1:0] prod_q, prod_step, prod_fin;
  logic [DWIDTH:0]     mul_sum;
  logic                neg_q, rneg_q;
  logic                accept, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [DWIDTH-1:0]   a_mag, b_mag, quo, rem, mul_res, div_res, imm_res;

  assign busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign waddr  = waddr_q;
  assign accept = start && !busy && !flush;

  // Operand decode: plain MUL is treated as unsigned since its low half is sign-agnostic.
  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && opA[DWIDTH-1];
    b_neg    = b_signed && opB[DWIDTH-1];
    a_mag    = a_neg ? -opA : opA;
    b_mag    = b_neg ? -opB : opB;
    div_zero = op_is_div(op) && (opB == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (opA == {1'b1, {(DWIDTH-1){1'b0}}}) && (&opB);
    if (div_zero) imm_res = op[1] ? opA : '1;
    else          imm_res = op[1] ? '0 : opA;
  end

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*DWIDTH-1:DWIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {mul_sum, prod_q[DWIDTH-1:1]};
    prod_fin  = neg_q ? -prod_step : prod_step;
    mul_res   = (op_q == OP_MUL) ? prod_fin[DWIDTH-1:0] : prod_fin[2*DWIDTH-1:DWIDTH];
    div_res   = op_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DWIDTH-1:0] fast_prod, fast_fin;
  logic [DWIDTH-1:0]   fast_res;
  always_comb begin
    fast_prod = {{DWIDTH{1'b0}}, a_mag} * {{DWIDTH{1'b0}}, b_mag};
    fast_fin  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
    fast_res  = (op == OP_MUL) ? fast_fin[DWIDTH-1:0] : fast_fin[2*DWIDTH-1:DWIDTH];
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    waddr_d  = waddr_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (state_q == ST_DONE) state_d = ST_IDLE;
          if (start) begin
            if (div_zero || div_ovf) begin
              state_d  = ST_DONE;
              result_d = imm_res;
              waddr_d  = rd;
            end else if (!op_is_div(op)) begin
`ifdef MULDIV_FAST_MUL_EN
              state_d  = ST_DONE;
              result_d = fast_res;
              waddr_d  = rd;
`else
              state_d  = ST_MUL;
`endif
            end else begin
              state_d = ST_DIV;
            end
          end
        end
        ST_MUL: if (cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = mul_res;
          waddr_d  = rd_q;
        end
        ST_DIV: if (cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = div_res;
          waddr_d  = rd_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_MUL;
      rd_q    <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else if (accept) begin
      op_q    <= op_e'(op);
      rd_q    <= rd;
      cnt_q   <= CW'(DWIDTH - 1);
      mcand_q <= a_mag;
      prod_q  <= {{DWIDTH{1'b0}}, b_mag};
      neg_q   <= a_neg ^ b_neg;
      rneg_q  <= a_neg;
    end else if (busy) begin
      cnt_q <= cnt_q - CW'(1);
      if (state_q == ST_MUL) prod_q <= prod_step;
    end
  end

  muldiv_div_core #(.DWIDTH(DWIDTH)) u_div_core (
    .clock_i     (clock),
    .reset_ni    (reset),
    .load_i      (accept && op_is_div(op)),
    .step_i      (state_q == ST_DIV),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, decoupled done monitor.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic [2:0] RST_OP = OP_DIVU;
`else
  localparam int MUL_LAT = 33;
  localparam logic [2:0] RST_OP = OP_MUL;
`endif

  logic        clock = 1'b0;
  logic        reset, start, flush, busy, done;
  logic [2:0]  op;
  logic [31:0] opA, opB, result;
  logic [4:0]  rd, waddr;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [36:0] exp_q[$];
  int          cyc_q[$];

  muldiv_unit #(.DWIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .rd(rd), .flush(flush), .busy(busy), .done(done), .result(result), .waddr(waddr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_done: got done with result=%h waddr=%0d, required no done", result, waddr);
      end else begin
        logic [36:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        compared += 3;
        if (result !== e[31:0]) begin
          mismatched++;
          $display("FAIL result: got %h, required %h", result, e[31:0]);
        end
        if (waddr !== e[36:32]) begin
          mismatched++;
          $display("FAIL waddr: got %0d, required %0d", waddr, e[36:32]);
        end
        if (cyc != ec) begin
          mismatched++;
          $display("FAIL latency: done at cycle %0d, required %0d", cyc, ec);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called at a negedge (cycle 0); returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [31:0] exp, input int lat);
    start = 1'b1; op = o; opA = a; opB = b; rd = r;
    exp_q.push_back({r, exp});
    cyc_q.push_back(cyc + lat);
    @(posedge clock); #1;
    start = 1'b0; opA = $urandom; opB = $urandom; op = 3'($urandom); rd = 5'($urandom);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < bound);
    if (!done) begin
      compared++; mismatched++;
      $display("FAIL wait_done: no done within %0d cycles, required done", bound);
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] r, input logic [31:0] exp, input int lat);
    issue(o, a, b, r, exp, lat);
    wait_done(60);
    @(negedge clock);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("result_hold", result, exp);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_bad;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; opA = '0; opB = '0; rd = '0;
    #3;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_waddr", {27'd0, waddr}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // MUL 7 * -3 with a start pulse during busy that must be ignored
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT);
`ifndef MULDIV_FAST_MUL_EN
    busy_bad = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      if (k == 5) begin start = 1'b1; op = OP_DIVU; opB = 32'd0; end
      if (k == 6) start = 1'b0;
      if (busy !== 1'b1) busy_bad++;
    end
    chk("busy_window", busy_bad, 32'd0);
`endif
    wait_done(60);
    @(negedge clock);
    chk("mul_done_one_cycle", {31'd0, done}, 32'd0);

    run(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, MUL_LAT);
    run(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, MUL_LAT);
    run(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, MUL_LAT);
    run(OP_DIV,    32'hFFFF_FFEC, 32'd3,         5'd4, 32'hFFFF_FFFA, 33);
    run(OP_REM,    32'hFFFF_FFEC, 32'd3,         5'd6, 32'hFFFF_FFFE, 33);
    run(OP_DIVU,   32'd100,       32'd0,         5'd7, 32'hFFFF_FFFF, 1);
    run(OP_REMU,   32'd100,       32'd0,         5'd8, 32'd100,       1);
    run(OP_DIVU,   32'd100,       32'd7,         5'd0, 32'd14,        33);
    run(OP_REMU,   32'd100,       32'd7,         5'd9, 32'd2,         33);

    // Reset in cycle 5 of an operation: outputs clear at once, no done afterwards
    start = 1'b1; op = RST_OP; opA = 32'd9; opB = 32'd9; rd = 5'd20;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_done", {31'd0, done}, 32'd0);
    chk("async_reset_result", result, 32'd0);
    chk("async_reset_waddr", {27'd0, waddr}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);

    // Flush in cycle 10 of DIVU together with a start that must be dropped
    start = 1'b1; op = OP_DIVU; opA = 32'd100; opB = 32'd7; rd = 5'd21;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(negedge clock);
    chk("busy_before_flush", {31'd0, busy}, 32'd1);
    flush = 1'b1; start = 1'b1; op = OP_DIVU; opB = 32'd0; rd = 5'd22;
    @(posedge clock); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clock);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clock);

    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
    run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1);

    // Back-to-back: second start accepted in the DONE cycle
    issue(OP_MUL, 32'd3, 32'd5, 5'd12, 32'd15, MUL_LAT);
    wait_done(60);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd13, 32'd14, 33);
    wait_done(60);
    @(negedge clock);
    chk("b2b_done_one_cycle", {31'd0, done}, 32'd0);
    chk("b2b_result_hold", result, 32'd14);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning operand/result width (XLEN).
REQ-002 The block SHALL have port clock  input  1  meaning the single system clock; all state updates on posedge clock.
REQ-003 The block SHALL have port reset  input  1  meaning asynchronous active-low reset (asserted at 0).
REQ-004 The block SHALL have port start  input  1  meaning request a new operation.
REQ-005 The block SHALL have port op  input  3  meaning RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-006 The block SHALL have ports opA, opB  input  DWIDTH  meaning source operands (register-file read data dR1, dR2).
REQ-007 The block SHALL have port rd  input  5  meaning destination register tag.
REQ-008 The block SHALL have port flush  input  1  meaning abort the in-flight operation.
REQ-009 The block SHALL have port busy  output  1  meaning an operation is executing; start is ignored.
REQ-010 The block SHALL have port done  output  1  meaning result valid for one cycle; drives register-file regw.
REQ-011 The block SHALL have ports result  output  DWIDTH  and  waddr  output  5, driving register-file wdata and waddr.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, DONE; busy=1 only in MUL or DIV; done=1 only in DONE.
REQ-013 start SHALL be accepted only when busy=0 (IDLE or DONE); opA, opB, op, rd captured at the accepting edge; later input changes ignored.
REQ-014 start while busy=1 SHALL be ignored with no state change.
REQ-015 Iterative multiply SHALL be shift-add over DWIDTH cycles: start in cycle 0 -> done in cycle DWIDTH+1.
REQ-016 Divide/remainder SHALL be restoring, DWIDTH iterations, same latency as REQ-015.
REQ-017 Signed ops SHALL operate on magnitudes and negate at the end; MULH/MULHSU/MULHU return the upper DWIDTH bits of the 2*DWIDTH product, MUL the lower.
REQ-018 Divide by zero SHALL skip iteration: done in cycle 1; quotient all-ones; remainder = opA.
REQ-019 Signed overflow (opA = most-negative, opB = -1) SHALL skip iteration: done in cycle 1; DIV = opA; REM = 0.
REQ-020 DONE SHALL last exactly one cycle, then IDLE, unless start is accepted in that cycle (back-to-back).
REQ-021 result and waddr SHALL hold their last values until the next DONE.
REQ-022 flush SHALL return the FSM to IDLE at the next edge with no done pulse; flush and start together: flush wins, start dropped.
REQ-023 waddr=0 SHALL still pulse done; the register file discards the write.

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, result=0, waddr=0 and clear all datapath registers.
REQ-025 reset mid-operation SHALL abandon it; no done pulse after release.

Configuration
REQ-026 With MULDIV_FAST_MUL_EN defined, all multiply ops SHALL use a single-cycle combinational product: done in cycle 1, MUL state unused.
REQ-027 Without MULDIV_FAST_MUL_EN, multiply SHALL follow REQ-015; divide behaviour is identical in both builds.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op encoding enum (funct3 values), FSM state enum and DWIDTH-independent constants.
REQ-029 The restoring divider datapath SHALL be sub-module muldiv_div_core (operands in, quotient/remainder out, step enable, load).

Verification
REQ-030 MUL opA=7, opB=-3 -> done in cycle 33, result=0xFFFFFFEB, waddr=rd; busy=1 cycles 1-32.
REQ-031 MULHU opA=opB=0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> result=0x00000000.
REQ-032 DIV opA=-20, opB=3 -> result=0xFFFFFFFA; REM same -> result=0xFFFFFFFE; DIVU 100/0 -> done in cycle 1, result=0xFFFFFFFF.
REQ-033 DIV opA=0x80000000, opB=-1 -> cycle 1, result=0x80000000; REM -> result=0.
REQ-034 DIVU started, flush at cycle 10 -> no done, busy=0 at cycle 11; new start at cycle 10 with flush -> ignored.
REQ-035 reset=0 asserted at cycle 5 of MUL -> outputs zero immediately; no done after release; back-to-back start in DONE cycle -> second result correct.
